// File: rtl/mips_pkg.sv
// Shared types and constants for the post-commit store buffer.
//   STB_DEPTH   default number of buffer entries
//   STB_AW/DW   address / data width carried in each entry
//   WORD_MASK   address bits that take part in load/store alias compares
//   stb_entry_t one buffered store {addr, data}
package mips_pkg;

    localparam int STB_DEPTH = 8;
    localparam int STB_AW    = 32;
    localparam int STB_DW    = 32;

    // Byte offset bits [1:0] are ignored: aliasing is resolved per word.
    localparam logic [STB_AW-1:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [STB_AW-1:0] addr;
        logic [STB_DW-1:0] data;
    } stb_entry_t;

    function automatic logic word_match(input logic [STB_AW-1:0] a,
                                        input logic [STB_AW-1:0] b);
        return ((a ^ b) & WORD_MASK) == '0;
    endfunction

endpackage

// File: rtl/stb_fwd_match.sv
// Youngest-match search over the store buffer for a load address.
// Ports:
//   entries   in   buffer storage, one stb_entry_t per slot
//   valid     in   per-slot occupancy mask
//   tail_idx  in   slot the next store will be written to
//   ld_addr   in   load address being checked
//   hit       out  at least one valid slot aliases ld_addr (word granularity)
//   index     out  slot of the youngest aliasing store (closest to tail)
module stb_fwd_match
    import mips_pkg::*;
#(
    parameter int DEPTH = STB_DEPTH,
    localparam int IW   = $clog2(DEPTH)
) (
    input  stb_entry_t [DEPTH-1:0] entries,
    input  logic [DEPTH-1:0]       valid,
    input  logic [IW-1:0]          tail_idx,
    input  logic [STB_AW-1:0]      ld_addr,
    output logic                   hit,
    output logic [IW-1:0]          index
);

    logic [IW-1:0] idx;

    // Walk from the oldest candidate (tail-DEPTH) to the youngest (tail-1);
    // later matches overwrite earlier ones, so the youngest one wins.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            idx = tail_idx - IW'(i + 1);
            if (valid[idx] && word_match(entries[idx].addr, ld_addr)) begin
                hit   = 1'b1;
                index = idx;
            end
        end
    end

endmodule

// File: rtl/store_commit_buffer.sv
// Post-commit store buffer: absorbs committed stores from the ROB one per
// cycle and drains them in order to data memory under a ready handshake.
// Loads are checked against all buffered stores for word aliasing.
// Entries are already architectural, so there is no flush input.
//
// Build option: define STB_FWD_EN to forward the youngest aliasing store's
// data to the load (ld_hit/ld_data); otherwise an alias raises ld_conflict
// and no forwarding mux is built.
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   in_we/in_addr/in_data committed store from the ROB
//   full, empty, count    occupancy status
//   mem_we/addr/data      head entry presented to data memory
//   mem_ready             memory accepts the head write this cycle
//   ld_addr               load address to check
//   ld_hit, ld_data       forwarding result (STB_FWD_EN builds only)
//   ld_conflict           alias present that cannot be forwarded
//   overflow              sticky: a store was lost because the buffer was full
//
// AW/DW must match the entry widths in mips_pkg.
module store_commit_buffer
    import mips_pkg::*;
#(
    parameter int DEPTH = STB_DEPTH,
    parameter int AW    = STB_AW,
    parameter int DW    = STB_DW,
    localparam int IW   = $clog2(DEPTH),
    localparam int PW   = IW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_we,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    output logic          full,
    output logic          empty,
    output logic [PW-1:0] count,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    input  logic          mem_ready,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hit,
    output logic [DW-1:0] ld_data,
    output logic          ld_conflict,
    output logic          overflow
);

    stb_entry_t [DEPTH-1:0] mem_q;
    logic [PW-1:0]          head_q, tail_q;
    logic                   drain, enq_ok;
    logic [DEPTH-1:0]       valid;
    logic                   fwd_hit;
    logic [IW-1:0]          fwd_idx;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count    = tail_q - head_q;
    assign empty    = (head_q == tail_q);
    assign full     = (count == PW'(DEPTH));
    assign mem_we   = !empty;
    assign mem_addr = mem_q[head_q[IW-1:0]].addr;
    assign mem_data = mem_q[head_q[IW-1:0]].data;

    assign drain  = mem_we && mem_ready;
    // A full buffer can still take a store when the head leaves on the same edge.
    assign enq_ok = in_we && (!full || drain);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            overflow <= 1'b0;
        end else begin
            if (drain)  head_q <= head_q + 1'b1;
            if (enq_ok) tail_q <= tail_q + 1'b1;
            if (in_we && !enq_ok) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_ok) mem_q[tail_q[IW-1:0]] <= {in_addr, in_data};
    end

    // Slot j is occupied when its distance from head is below count.
    always_comb begin
        valid = '0;
        for (int j = 0; j < DEPTH; j++) begin
            valid[j] = {1'b0, IW'(j) - head_q[IW-1:0]} < count;
        end
    end

    stb_fwd_match #(.DEPTH(DEPTH)) u_match (
        .entries  (mem_q),
        .valid    (valid),
        .tail_idx (tail_q[IW-1:0]),
        .ld_addr  (ld_addr),
        .hit      (fwd_hit),
        .index    (fwd_idx)
    );

`ifdef STB_FWD_EN
    assign ld_hit      = fwd_hit;
    assign ld_data     = fwd_hit ? mem_q[fwd_idx].data : '0;
    assign ld_conflict = 1'b0;
`else
    logic [IW-1:0] unused_fwd_idx;
    assign unused_fwd_idx = fwd_idx;
    assign ld_hit         = 1'b0;
    assign ld_data        = '0;
    assign ld_conflict    = fwd_hit;
`endif

endmodule
